// File: rtl/button_input_bank_pkg.sv
// Shared constants and helpers for the button input bank: default parameters,
// channel index names and a width helper.
package button_input_bank_pkg;

    localparam int DEF_CHANNELS      = 5;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 16;
    localparam int DEF_REPEAT_DELAY  = 256;
    localparam int DEF_REPEAT_RATE   = 64;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_UP     = 2;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_CENTER = 4;

    // Ceiling log2, never below 1 so a single-channel bank still has an index bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_input_bank_if.sv
// Button bank bus: raw levels in, debounced levels, pulses and summary flags out.
// The master side is the bank itself; the slave side is the consuming game logic.
interface button_input_bank_if
    import button_input_bank_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS
);
    localparam int IDX_W = clog2(CHANNELS);

    logic [CHANNELS-1:0] Signal;
    logic [CHANNELS-1:0] Level;
    logic [CHANNELS-1:0] Pressed;
    logic [CHANNELS-1:0] Released;
    logic                AnyPressed;
    logic [IDX_W-1:0]    LastPressed;

    modport master (
        input  Signal,
        output Level, Pressed, Released, AnyPressed, LastPressed
    );

    modport slave (
        output Signal,
        input  Level, Pressed, Released, AnyPressed, LastPressed
    );

endinterface

// File: rtl/button_debounce_channel.sv
// One button channel: synchroniser, debounce counter, press/release pulses and,
// when BUTTON_AUTO_REPEAT_EN is defined, hold-to-repeat press pulses.
module button_debounce_channel
    import button_input_bank_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE   = DEF_REPEAT_RATE
) (
    input  logic Clock,
    input  logic Reset,
    input  logic rawSignal,
    output logic level,
    output logic pressed,
    output logic released,
    output logic levelNext,
    output logic pressedNext
);
    localparam int               CNT_W    = clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] syncChain;
    logic [CNT_W-1:0]       debCnt;
    logic [CNT_W-1:0]       debCntNext;
    logic                   syncLevel;
    logic                   toggle;
    logic                   rise;
    logic                   fall;
    logic                   repeatFire;

    assign syncLevel = syncChain[SYNC_STAGES-1];

    // Level only flips once the synchronised input has disagreed for STABLE_CYCLES edges.
    always_comb begin
        toggle      = (syncLevel != level) && (debCnt == CNT_LAST);
        debCntNext  = ((syncLevel == level) || toggle) ? '0 : debCnt + CNT_W'(1);
        levelNext   = level ^ toggle;
        rise        = toggle & ~level;
        fall        = toggle & level;
        pressedNext = rise | repeatFire;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            syncChain <= '0;
            debCnt    <= '0;
            level     <= 1'b0;
            pressed   <= 1'b0;
            released  <= 1'b0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], rawSignal};
            debCnt    <= debCntNext;
            level     <= levelNext;
            pressed   <= pressedNext;
            released  <= fall;
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int                HOLD_W     = clog2(maxInt(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);

    logic [HOLD_W-1:0] holdCnt;
    logic [HOLD_W-1:0] holdCntNext;
    logic              repeating;
    logic              repeatingNext;

    // A falling Level on this edge suppresses any repeat so Released wins.
    always_comb begin
        repeatFire    = level && !toggle &&
                        (holdCnt == (repeating ? RATE_LAST : DELAY_LAST));
        repeatingNext = level && !toggle && (repeating || repeatFire);
        if (!level || toggle || repeatFire) holdCntNext = '0;
        else                                holdCntNext = holdCnt + HOLD_W'(1);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            holdCnt   <= '0;
            repeating <= 1'b0;
        end else begin
            holdCnt   <= holdCntNext;
            repeating <= repeatingNext;
        end
    end
`else
    assign repeatFire = 1'b0;

    // Repeat timing has no effect in this build; the parameters stay for a uniform interface.
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : gRepeatIdle
    end
`endif

endmodule

// File: rtl/button_input_bank.sv
// Multi-channel button front end: one debounce channel per input plus the
// AnyPressed flag and LastPressed index. Optional macro: BUTTON_AUTO_REPEAT_EN.
module button_input_bank
    import button_input_bank_pkg::*;
#(
    parameter int CHANNELS      = DEF_CHANNELS,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE   = DEF_REPEAT_RATE
) (
    input  logic                Clock,
    input  logic                Reset,
    button_input_bank_if.master bus
);
    localparam int IDX_W = clog2(CHANNELS);

    logic [CHANNELS-1:0] levelVec;
    logic [CHANNELS-1:0] pressedVec;
    logic [CHANNELS-1:0] releasedVec;
    logic [CHANNELS-1:0] levelNextVec;
    logic [CHANNELS-1:0] pressedNextVec;
    logic [IDX_W-1:0]    lowestIdx;
    logic [IDX_W-1:0]    lastPressed;
    logic                anyPressed;

    for (genvar i = 0; i < CHANNELS; i++) begin : gChannel
        button_debounce_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) uChannel (
            .Clock      (Clock),
            .Reset      (Reset),
            .rawSignal  (bus.Signal[i]),
            .level      (levelVec[i]),
            .pressed    (pressedVec[i]),
            .released   (releasedVec[i]),
            .levelNext  (levelNextVec[i]),
            .pressedNext(pressedNextVec[i])
        );
    end

    // Summary flags are registered from the channels' next-state values so they
    // line up with Level and Pressed in the same cycle; the lowest index wins a tie.
    always_comb begin
        lowestIdx = lastPressed;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pressedNextVec[i]) lowestIdx = IDX_W'(i);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            anyPressed  <= 1'b0;
            lastPressed <= '0;
        end else begin
            anyPressed  <= |levelNextVec;
            lastPressed <= lowestIdx;
        end
    end

    assign bus.Level       = levelVec;
    assign bus.Pressed     = pressedVec;
    assign bus.Released    = releasedVec;
    assign bus.AnyPressed  = anyPressed;
    assign bus.LastPressed = lastPressed;

endmodule
